// File: rtl/dm_store_buffer.sv
// Posted-write store buffer in front of the data memory: stores are queued in
// program order, drained one per free dm cycle, and forwarded to probing loads.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          St_valid,
  input  logic [AW-1:0] St_addr,
  input  logic [DW-1:0] St_data,
  output logic          St_ready,
  input  logic [AW-1:0] Ld_addr,
  output logic          Ld_hit,
  output logic [DW-1:0] Ld_data,
  input  logic          Dm_busy,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          Memwrite,
  output logic          Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          drain;
  logic [PW-1:0] probe_idx;

  // Store handshake: a store transfers on the rising edge where St_valid and
  // St_ready are both high; St_ready depends only on the occupancy count, so a
  // full buffer refuses even when a drain frees a slot on that same edge.
  assign Empty    = (count == '0);
  assign St_ready = (count < FULL);
  assign Memwrite = !Empty && !Dm_busy;
  assign A        = Empty ? '0 : addr_q[head];
  assign D        = Empty ? '0 : data_q[head];
  assign push     = St_valid && St_ready;
  assign drain    = Memwrite;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: only entries inside [head, head+count) are ever observed.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_q[tail] <= St_addr;
      data_q[tail] <= St_data;
    end
  end

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    Ld_hit    = 1'b0;
    Ld_data   = '0;
    probe_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      probe_idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[probe_idx] == Ld_addr)) begin
        Ld_hit  = 1'b1;
        Ld_data = data_q[probe_idx];
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: directed scenarios plus a scoreboard that checks
// every dm write against the order in which stores were accepted.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          dm_busy;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic          memwrite;
  logic          empty;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    dm_mem [32];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               drains   = 0;

  dm_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(clk), .Reset(rst_n),
    .St_valid(st_valid), .St_addr(st_addr), .St_data(st_data), .St_ready(st_ready),
    .Ld_addr(ld_addr), .Ld_hit(ld_hit), .Ld_data(ld_data),
    .Dm_busy(dm_busy), .A(a), .D(d), .Memwrite(memwrite), .Empty(empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: dm samples on the next rising edge; inputs only change just after rising edges
  always @(negedge clk) begin
    if (rst_n === 1'b1 && memwrite === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL drain_unexpected: got write A=%0d D=%h, required no write", a, d);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({a, d} !== e) begin
          n_fail++;
          $display("FAIL drain_order: got A=%0d D=%h, required A=%0d D=%h",
                   a, d, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
      dm_mem[a] = d;
      drains++;
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] sa, input logic [DW-1:0] sd);
    int w;
    w = 0;
    st_valid = 1'b1;
    st_addr  = sa;
    st_data  = sd;
    @(negedge clk);
    while (!st_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (!st_ready) begin
      n_fail++;
      $display("FAIL store_timeout: got st_ready=%b after %0d cycles, required 1", st_ready, w);
    end else begin
      exp_q.push_back({sa, sd});
    end
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int w;
    w = 0;
    @(negedge clk);
    while (!empty && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_timeout: got empty=%b, required 1", empty);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({st_ready, empty, memwrite, ld_hit} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_flags: got ready/empty/mw/hit=%b, required 1100",
               {st_ready, empty, memwrite, ld_hit});
    end
    n_checks++;
    if (a !== '0 || d !== '0 || ld_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got A=%0d D=%h ld_data=%h, required 0", a, d, ld_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (memwrite !== 1'b0 || empty !== 1'b1) begin
        n_fail++;
        $display("FAIL idle: got memwrite=%b empty=%b, required 0/1", memwrite, empty);
      end
    end
    tick();
  endtask

  task automatic test_single();
    dm_busy = 1'b0;
    store(5'd3, 32'hAAAAAAAA);
    ld_addr = 5'd3;
    @(negedge clk);
    n_checks++;
    if (memwrite !== 1'b1 || a !== 5'd3 || d !== 32'hAAAAAAAA) begin
      n_fail++;
      $display("FAIL single_drain: got mw=%b A=%0d D=%h, required 1/3/aaaaaaaa", memwrite, a, d);
    end
    n_checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'hAAAAAAAA) begin
      n_fail++;
      $display("FAIL fwd_draining: got hit=%b data=%h, required 1/aaaaaaaa", ld_hit, ld_data);
    end
    tick();
    n_checks++;
    if (empty !== 1'b1 || dm_mem[3] !== 32'hAAAAAAAA) begin
      n_fail++;
      $display("FAIL single_after: got empty=%b dm[3]=%h, required 1/aaaaaaaa", empty, dm_mem[3]);
    end
  endtask

  task automatic test_fill();
    int d0;
    d0 = drains;
    dm_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) store(AW'(i), 32'hF000_0000 + DW'(i));
    @(negedge clk);
    n_checks++;
    if (st_ready !== 1'b0 || empty !== 1'b0 || memwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags: got ready=%b empty=%b mw=%b, required 0/0/0", st_ready, empty, memwrite);
    end
    tick();
    st_valid = 1'b1;
    st_addr  = 5'd4;
    st_data  = 32'hF000_0004;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (st_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL held_store: got st_ready=%b, required 0", st_ready);
      end
      tick();
    end
    dm_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (st_ready !== 1'b0 || memwrite !== 1'b1 || a !== 5'd0) begin
      n_fail++;
      $display("FAIL no_passthrough: got ready=%b mw=%b A=%0d, required 0/1/0", st_ready, memwrite, a);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_drain: got st_ready=%b, required 1", st_ready);
    end else begin
      exp_q.push_back({5'd4, 32'hF000_0004});
    end
    tick();
    st_valid = 1'b0;
    wait_empty();
    n_checks++;
    if (drains - d0 != 5) begin
      n_fail++;
      $display("FAIL fill_drain_count: got %0d, required 5", drains - d0);
    end
  endtask

  task automatic test_forward();
    dm_busy = 1'b1;
    store(5'd2, 32'h11111111);
    store(5'd2, 32'h55555555);
    ld_addr = 5'd2;
    #1;
    n_checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h55555555) begin
      n_fail++;
      $display("FAIL fwd_youngest: got hit=%b data=%h, required 1/55555555", ld_hit, ld_data);
    end
    ld_addr = 5'd7;
    #1;
    n_checks++;
    if (ld_hit !== 1'b0 || ld_data !== '0) begin
      n_fail++;
      $display("FAIL fwd_miss: got hit=%b data=%h, required 0/0", ld_hit, ld_data);
    end
    store(5'd5, 32'h77777777);
    ld_addr = 5'd2;
    #1;
    n_checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h55555555) begin
      n_fail++;
      $display("FAIL fwd_older_kept: got hit=%b data=%h, required 1/55555555", ld_hit, ld_data);
    end
    // a store on the port this cycle must not be visible yet
    st_valid = 1'b1;
    st_addr  = 5'd6;
    st_data  = 32'h99999999;
    ld_addr  = 5'd6;
    @(negedge clk);
    n_checks++;
    if (ld_hit !== 1'b0 || ld_data !== '0) begin
      n_fail++;
      $display("FAIL fwd_same_cycle: got hit=%b data=%h, required 0/0", ld_hit, ld_data);
    end
    if (st_ready) exp_q.push_back({5'd6, 32'h99999999});
    tick();
    st_valid = 1'b0;
    n_checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h99999999) begin
      n_fail++;
      $display("FAIL fwd_after_accept: got hit=%b data=%h, required 1/99999999", ld_hit, ld_data);
    end
    dm_busy = 1'b0;
    wait_empty();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    int d0;
    d0 = drains;
    dm_busy = 1'b0;
    pa = '0;
    pd = '0;
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1;
      st_addr  = AW'($urandom_range(0, 31));
      st_data  = $urandom;
      ld_addr  = pa;
      @(negedge clk);
      n_checks++;
      if (st_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready: got %b, required 1", st_ready);
      end
      if (i > 0) begin
        n_checks++;
        if (memwrite !== 1'b1 || a !== pa || d !== pd || ld_hit !== 1'b1 || ld_data !== pd) begin
          n_fail++;
          $display("FAIL b2b_drain: got mw=%b A=%0d D=%h hit=%b ld=%h, required 1/%0d/%h/1/%h",
                   memwrite, a, d, ld_hit, ld_data, pa, pd, pd);
        end
      end
      exp_q.push_back({st_addr, st_data});
      pa = st_addr;
      pd = st_data;
      tick();
    end
    st_valid = 1'b0;
    wait_empty();
    n_checks++;
    if (drains - d0 != 10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got drains=%0d left=%0d, required 10/0", drains - d0, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = AW'($urandom_range(0, 31));
      st_data  = $urandom;
      dm_busy  = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (st_valid && st_ready) exp_q.push_back({st_addr, st_data});
      tick();
    end
    st_valid = 1'b0;
    dm_busy  = 1'b0;
    wait_empty();
  endtask

  task automatic test_reset_mid();
    int d0;
    dm_busy = 1'b1;
    store(5'd10, 32'hA0A0A0A0);
    store(5'd11, 32'hA1A1A1A1);
    store(5'd12, 32'hA2A2A2A2);
    #2;
    dm_busy = 1'b0;
    rst_n   = 1'b0;
    exp_q.delete();
    d0 = drains;
    #1;
    n_checks++;
    if (memwrite !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1 || a !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got mw=%b empty=%b ready=%b A=%0d, required 0/1/1/0",
               memwrite, empty, st_ready, a);
    end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (drains != d0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL discard: got writes=%0d empty=%b, required 0/1", drains - d0, empty);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dm_mem[i] = '0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = '0;
    dm_busy  = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d pending expected writes, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
